// File: rtl/nibble_add_seq.sv
// Sequential 16-bit adder/subtractor that feeds one 4-bit carry-lookahead
// adder one nibble per cycle, LSB nibble first, under a three-state FSM.

module ahead_adder (
  input  logic [3:0] AA_A,
  input  logic [3:0] AA_B,
  input  logic       AA_C_0,
  output logic [3:0] AA_F,
  output logic       AA_C_4
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:0] c;

  // Carry-lookahead: every carry is formed directly from generate/propagate terms.
  always_comb begin
    gen  = AA_A & AA_B;
    prop = AA_A ^ AA_B;
    c[0] = AA_C_0;
    c[1] = gen[0] | (prop[0] & AA_C_0);
    c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & AA_C_0);
    c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
         | (prop[2] & prop[1] & prop[0] & AA_C_0);
    c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
         | (prop[3] & prop[2] & prop[1] & gen[0])
         | (prop[3] & prop[2] & prop[1] & prop[0] & AA_C_0);
    AA_F   = prop ^ c[3:0];
    AA_C_4 = c[4];
  end

endmodule

module nibble_add_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        NS_START,
  input  logic        NS_SUB,
  input  logic [15:0] NS_A,
  input  logic [15:0] NS_B,
  output logic        NS_BUSY,
  output logic        NS_DONE,
  output logic [15:0] NS_SUM,
  output logic        NS_COUT,
  output logic        NS_OVF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic        sub_reg;
  logic [1:0]  idx;
  logic        carry;

  logic [3:0]  aa_a;
  logic [3:0]  b_nib;
  logic [3:0]  aa_b;
  logic [3:0]  aa_f;
  logic        aa_c4;
  logic        c_into_msb;
  logic [15:0] sum_ins;

  ahead_adder u_ahead_adder (
    .AA_A   (aa_a),
    .AA_B   (aa_b),
    .AA_C_0 (carry),
    .AA_F   (aa_f),
    .AA_C_4 (aa_c4)
  );

  // Select the current nibble and merge the adder result into the running sum.
  always_comb begin
    aa_a    = 4'h0;
    b_nib   = 4'h0;
    sum_ins = NS_SUM;
    case (idx)
      2'd0: begin aa_a = a_reg[3:0];   b_nib = b_reg[3:0];   end
      2'd1: begin aa_a = a_reg[7:4];   b_nib = b_reg[7:4];   end
      2'd2: begin aa_a = a_reg[11:8];  b_nib = b_reg[11:8];  end
      2'd3: begin aa_a = a_reg[15:12]; b_nib = b_reg[15:12]; end
      default: begin aa_a = 4'h0; b_nib = 4'h0; end
    endcase
    aa_b = sub_reg ? ~b_nib : b_nib;
    case (idx)
      2'd0: sum_ins[3:0]   = aa_f;
      2'd1: sum_ins[7:4]   = aa_f;
      2'd2: sum_ins[11:8]  = aa_f;
      2'd3: sum_ins[15:12] = aa_f;
      default: sum_ins = NS_SUM;
    endcase
    // Carry into bit 15 recovered from the top bit's sum: f = a ^ b ^ cin.
    c_into_msb = aa_a[3] ^ aa_b[3] ^ aa_f[3];
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = NS_START ? RUN : IDLE;
      RUN:     state_next = (idx == 2'd3) ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      a_reg   <= 16'h0000;
      b_reg   <= 16'h0000;
      sub_reg <= 1'b0;
      idx     <= 2'd0;
      carry   <= 1'b0;
      NS_BUSY <= 1'b0;
      NS_DONE <= 1'b0;
      NS_SUM  <= 16'h0000;
      NS_COUT <= 1'b0;
      NS_OVF  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          NS_DONE <= 1'b0;
          if (NS_START) begin
            a_reg   <= NS_A;
            b_reg   <= NS_B;
            sub_reg <= NS_SUB;
            idx     <= 2'd0;
            carry   <= NS_SUB;
            NS_BUSY <= 1'b1;
          end else begin
            NS_BUSY <= 1'b0;
          end
        end
        RUN: begin
          NS_SUM <= sum_ins;
          carry  <= aa_c4;
          idx    <= idx + 2'd1;
          if (idx == 2'd3) begin
            NS_COUT <= aa_c4;
            NS_OVF  <= aa_c4 ^ c_into_msb;
            NS_BUSY <= 1'b0;
            NS_DONE <= 1'b1;
          end else begin
            NS_BUSY <= 1'b1;
            NS_DONE <= 1'b0;
          end
        end
        DONE: begin
          NS_BUSY <= 1'b0;
          NS_DONE <= 1'b0;
        end
        default: begin
          NS_BUSY <= 1'b0;
          NS_DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 NS_START  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 NS_SUB  input  1  0 = A+B, 1 = A-B; sampled with NS_START.
REQ-006 NS_A  input  16  operand A, unsigned or two's complement; sampled with NS_START.
REQ-007 NS_B  input  16  operand B; sampled with NS_START.
REQ-008 NS_BUSY  output  1  high while the block is in RUN.
REQ-009 NS_DONE  output  1  one-cycle pulse; results are valid.
REQ-010 NS_SUM  output  16  result.
REQ-011 NS_COUT  output  1  carry out of bit 15; for subtract, 1 = no borrow.
REQ-012 NS_OVF  output  1  two's-complement signed overflow.

Function
REQ-013 The block SHALL compute the 16-bit result through exactly one internal AHEAD_ADDER instance (4-bit carry-lookahead; ports AA_A, AA_B, AA_C_0, AA_F, AA_C_4), one nibble per cycle, LSB nibble first.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE -> RUN: when NS_START=1 in IDLE, the block SHALL latch NS_A, NS_B and NS_SUB, clear the nibble index to 0 and set the carry register to NS_SUB.
REQ-016 In RUN, the adder inputs SHALL be AA_A = A[4i+3:4i], AA_B = B[4i+3:4i] (bitwise inverted when SUB=1) and AA_C_0 = carry register, where i is the nibble index.
REQ-017 At each RUN edge, AA_F SHALL be written to NS_SUM[4i+3:4i], AA_C_4 SHALL be written to the carry register, and i SHALL increment.
REQ-018 RUN -> DONE: at the edge where i=3, NS_COUT SHALL take AA_C_4, NS_OVF SHALL take AA_C_4 XOR the carry into bit 15, and the state SHALL become DONE.
REQ-019 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-020 Latency: if NS_START is sampled at edge k, NS_BUSY SHALL be high in cycles k+1 to k+4 and NS_DONE SHALL be high in cycle k+5 only.
REQ-021 NS_BUSY SHALL be low in IDLE and in DONE.
REQ-022 NS_START SHALL be ignored in RUN and in DONE; no queuing.
REQ-023 If NS_START is held high continuously, the next operation SHALL be accepted in the IDLE cycle following DONE, so a new operation can start every 6 cycles.
REQ-024 NS_SUM, NS_COUT and NS_OVF SHALL hold their values from DONE until the next accepted start.
REQ-025 During RUN, partial NS_SUM values are not valid and SHALL NOT be relied on.
REQ-026 Operand changes after acceptance SHALL NOT affect the result in progress.
REQ-027 Arithmetic SHALL wrap modulo 2^16; no saturation.

Reset
REQ-028 When RST=1 at an edge, the state SHALL become IDLE, and NS_BUSY, NS_DONE, NS_SUM, NS_COUT, NS_OVF, the nibble index, the carry register and the latched operands SHALL all become 0.
REQ-029 RST SHALL take priority over NS_START.
REQ-030 RST asserted during RUN or DONE SHALL abort the operation with no NS_DONE pulse.
REQ-031 A start after reset deassertion SHALL behave as from power-up.

Verification
REQ-032 Add 0x1234 + 0x4321, start at edge k -> NS_BUSY high in cycles k+1 to k+4; NS_DONE in k+5 with SUM=0x5555, COUT=0, OVF=0.
REQ-033 Add 0xFFFF + 0x0001 -> SUM=0x0000, COUT=1, OVF=0 (carry propagates through all four nibbles).
REQ-034 Add 0x7FFF + 0x0001 -> SUM=0x8000, COUT=0, OVF=1.
REQ-035 Sub 0x0005 - 0x0007 -> SUM=0xFFFE, COUT=0, OVF=0.
REQ-036 Sub 0x8000 - 0x0001 -> SUM=0x7FFF, COUT=1, OVF=1.
REQ-037 Start with 0x0001 + 0x0001, then pulse NS_START with 0xAAAA + 0x5555 during RUN -> second request ignored; DONE gives SUM=0x0002; results held until the next start.
REQ-038 Hold NS_START high with fixed operands -> NS_DONE pulses exactly every 6 cycles.
REQ-039 Assert RST in the 2nd RUN cycle -> next cycle all outputs 0 and state IDLE; no NS_DONE; a following 0x0003 + 0x0004 gives SUM=0x0007.
